range_encoder_renormalizer: RTL and testbench
=============================================

# range_encoder_renormalizer

Encoder-side counterpart of the entropy decoder's range normalizer. After each symbol interval update it accepts a 16-bit [low, high] interval and renormalizes it with E1/E2/E3 scaling, one scaling step per cycle. It emits the resolved code bits, including deferred underflow (pending) bits, on a single-bit valid/ready stream. It sits between the LiDAR encoder's interval calculator and the bitstream packer, and on request terminates the stream with a flush sequence.

## Interface
- PEND_W, 8: width of the pending-bit counter.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  interval update present.
- in_ready  out  1  high only in IDLE.
- low_in  in  16  interval low bound, inclusive.
- high_in  in  16  interval high bound, inclusive.
- flush  in  1  terminate request; sampled only in IDLE when in_valid=0.
- bit_valid  out  1  output code bit present.
- bit_out  out  1  code bit.
- bit_ready  in  1  packer accepts the bit.
- norm_valid  out  1  one-cycle pulse; low_out/high_out hold the normalized interval.
- low_out  out  16  normalized low; holds until the next norm_valid.
- high_out  out  16  normalized high; holds until the next norm_valid.
- pending_count  out  PEND_W  current count of deferred bits.
- overflow_flag  out  1  sticky; pending counter saturated. Cleared only by reset.
- error_flag  out  1  sticky; an input with low_in > high_in was received. Cleared only by reset.
- flush_done  out  1  one-cycle pulse when the flush sequence completes.

## Operation
- Reset values: all outputs 0, state IDLE. in_ready becomes 1 in the first cycle after reset deasserts.
- States: IDLE, CHECK, EMIT, EMIT_PEND, DONE, FLUSH.
- IDLE:
  - in_valid=1: capture low/high, go to CHECK. in_valid has priority over flush.
  - Otherwise, if flush=1: go to FLUSH.
- CHECK evaluates one rule per cycle, in priority order:
  - Input with low > high: set error_flag; treat as the "none" case. The interval passes through unchanged.
  - E1 (high < 0x8000): first bit 0. low = low<<1; high = (high<<1)|1. Go to EMIT.
  - E2 (low >= 0x8000): first bit 1. low = (low-0x8000)<<1; high = ((high-0x8000)<<1)|1. Go to EMIT.
  - E3 (low >= 0x4000 and high < 0xC000): pending += 1. low = (low-0x4000)<<1; high = ((high-0x4000)<<1)|1. Stay in CHECK.
  - None: go to DONE.
- All arithmetic is 16-bit; the shifted-out MSB is discarded.
- EMIT: bit_valid=1 with the first bit.
  - On handshake with pending > 0: go to EMIT_PEND with bit_out = inverted first bit.
  - On handshake with pending = 0: return to CHECK, or finish the flush.
- EMIT_PEND: each handshake decrements pending. When pending reaches 0, return to CHECK (or finish the flush).
- DONE: norm_valid=1 for one cycle; low_out/high_out update in the same cycle. Then go to IDLE.
- FLUSH, single cycle:
  - pending += 1.
  - low < 0x4000: first bit 0. Otherwise: first bit 1.
  - Go to EMIT.
  - When the final bit is accepted: pulse flush_done, clear pending, set low=0x0000 and high=0xFFFF, go to IDLE.
- Pending saturation: an increment at all-ones holds the value and sets overflow_flag.

## Timing
- Input handshake: in_valid & in_ready at edge N. CHECK runs in cycle N+1.
- With no scaling: norm_valid at cycle N+2, in_ready at N+3.
- Each E3 step costs 1 cycle.
- Each E1/E2 step costs 1 CHECK cycle plus one cycle per emitted bit at bit_ready=1.
- bit_valid and bit_out hold stable until bit_ready=1. Backpressure stalls indefinitely without state loss.
- A bit transfers on each cycle where bit_valid & bit_ready are both high. Back-to-back bits need no idle cycles.
- A valid interval (low <= high) needs at most 16 scaling steps before DONE.
- Reset mid-operation: state, pending, and all outputs return to reset values immediately; a partially emitted sequence is dropped.

## Test plan
- No scaling: low=0x2000, high=0xDFFF, bit_ready=1 -> no bits; norm_valid at N+2; low_out=0x2000, high_out=0xDFFF.
- Double E1: low=0x0000, high=0x3FFF -> bits 0,0; low_out=0x0000, high_out=0xFFFF.
- E2: low=0x9000, high=0xFFFF -> bit 1; low_out=0x2000, high_out=0xFFFF.
- E3 then E1:
  - low=0x4000, high=0xBFFF -> no bits; pending_count=1; low_out=0x0000, high_out=0xFFFF.
  - Then low=0x0000, high=0x7FFF -> bits 0,1; pending_count=0; high_out=0xFFFF.
- Backpressure and reset: hold bit_ready=0 for 5 cycles during a bit -> bit_valid and bit_out stable. Assert reset mid-EMIT -> all outputs 0, in_ready=1 the cycle after reset deasserts.
- Flush: pending=2, low=0x2000 -> bits 0,1,1,1; flush_done pulses; pending_count=0.
- PEND_W=2 with 4 E3 steps -> pending_count=3 and overflow_flag=1.

Source files
------------

// File: rtl/range_encoder_renormalizer.sv
// rtl/range_encoder_renormalizer.sv - E1/E2/E3 interval renormalizer emitting code and pending bits
// One scaling step per CHECK cycle; resolved bits leave on a single-bit valid/ready stream.
module range_encoder_renormalizer #(
   parameter int PEND_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       low_in,
   input  logic [15:0]       high_in,
   input  logic              flush,
   output logic              bit_valid,
   output logic              bit_out,
   input  logic              bit_ready,
   output logic              norm_valid,
   output logic [15:0]       low_out,
   output logic [15:0]       high_out,
   output logic [PEND_W-1:0] pending_count,
   output logic              overflow_flag,
   output logic              error_flag,
   output logic              flush_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_EMIT,
      S_EMIT_PEND,
      S_DONE,
      S_FLUSH
   } state_t;

   localparam logic [PEND_W-1:0] PEND_MAX = '1;
   localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

   state_t            r_state, w_next;
   logic [15:0]       r_low, r_high, w_low_nx, w_high_nx;
   logic [15:0]       r_low_out, r_high_out;
   logic [PEND_W-1:0] r_pend, w_pend_nx, w_pend_inc;
   logic              r_bit, w_bit_nx;
   logic              r_flushing, w_flushing_nx;
   logic              r_err, w_err_nx;
   logic              r_ovf, w_ovf_nx, w_ovf_inc;
   logic              r_flush_done, w_flush_done_nx;
   logic              w_load_out, w_finish;
   logic              w_bad, w_e1, w_e2, w_e3;
   logic [15:0]       w_low_m4, w_high_m4;

   assign w_bad     = (r_low > r_high);
   assign w_e1      = (r_high < 16'h8000);
   assign w_e2      = (r_low >= 16'h8000);
   assign w_e3      = (r_low >= 16'h4000) && (r_high < 16'hC000);
   assign w_low_m4  = r_low - 16'h4000;
   assign w_high_m4 = r_high - 16'h4000;

   // Saturating pending increment shared by E3 and the flush step.
   assign w_ovf_inc  = (r_pend == PEND_MAX);
   assign w_pend_inc = w_ovf_inc ? r_pend : r_pend + PEND_ONE;

   always_comb begin
      w_next          = r_state;
      w_low_nx        = r_low;
      w_high_nx       = r_high;
      w_pend_nx       = r_pend;
      w_bit_nx        = r_bit;
      w_flushing_nx   = r_flushing;
      w_err_nx        = r_err;
      w_ovf_nx        = r_ovf;
      w_flush_done_nx = 1'b0;
      w_load_out      = 1'b0;
      w_finish        = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_low_nx  = low_in;
               w_high_nx = high_in;
               w_next    = S_CHECK;
            end else if (flush) begin
               w_next = S_FLUSH;
            end
         end
         S_CHECK: begin
            if (w_bad) begin
               w_err_nx   = 1'b1;
               w_load_out = 1'b1;
               w_next     = S_DONE;
            end else if (w_e1 || w_e2) begin
               // E1 and E2 share the shift: bit 15 is discarded either way.
               w_bit_nx  = w_e2 && !w_e1;
               w_low_nx  = {r_low[14:0], 1'b0};
               w_high_nx = {r_high[14:0], 1'b1};
               w_next    = S_EMIT;
            end else if (w_e3) begin
               w_pend_nx = w_pend_inc;
               w_ovf_nx  = r_ovf | w_ovf_inc;
               w_low_nx  = {w_low_m4[14:0], 1'b0};
               w_high_nx = {w_high_m4[14:0], 1'b1};
            end else begin
               w_load_out = 1'b1;
               w_next     = S_DONE;
            end
         end
         S_EMIT: begin
            if (bit_ready) begin
               if (r_pend != '0) begin
                  w_next = S_EMIT_PEND;
               end else begin
                  w_finish = 1'b1;
               end
            end
         end
         S_EMIT_PEND: begin
            if (bit_ready) begin
               w_pend_nx = r_pend - PEND_ONE;
               w_finish  = (r_pend == PEND_ONE);
            end
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         S_FLUSH: begin
            w_pend_nx     = w_pend_inc;
            w_ovf_nx      = r_ovf | w_ovf_inc;
            w_bit_nx      = (r_low >= 16'h4000);
            w_flushing_nx = 1'b1;
            w_next        = S_EMIT;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase

      if (w_finish) begin
         if (r_flushing) begin
            w_next          = S_IDLE;
            w_flushing_nx   = 1'b0;
            w_flush_done_nx = 1'b1;
            w_pend_nx       = '0;
            w_low_nx        = 16'h0000;
            w_high_nx       = 16'hFFFF;
         end else begin
            w_next = S_CHECK;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_low        <= 16'h0000;
         r_high       <= 16'h0000;
         r_low_out    <= 16'h0000;
         r_high_out   <= 16'h0000;
         r_pend       <= '0;
         r_bit        <= 1'b0;
         r_flushing   <= 1'b0;
         r_err        <= 1'b0;
         r_ovf        <= 1'b0;
         r_flush_done <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_low        <= w_low_nx;
         r_high       <= w_high_nx;
         r_pend       <= w_pend_nx;
         r_bit        <= w_bit_nx;
         r_flushing   <= w_flushing_nx;
         r_err        <= w_err_nx;
         r_ovf        <= w_ovf_nx;
         r_flush_done <= w_flush_done_nx;
         if (w_load_out) begin
            r_low_out  <= r_low;
            r_high_out <= r_high;
         end
      end
   end

   // Gated by reset so in_ready stays low while reset is held.
   assign in_ready      = (r_state == S_IDLE) && !reset;
   assign bit_valid     = (r_state == S_EMIT) || (r_state == S_EMIT_PEND);
   assign bit_out       = bit_valid && ((r_state == S_EMIT_PEND) ? !r_bit : r_bit);
   assign norm_valid    = (r_state == S_DONE);
   assign low_out       = r_low_out;
   assign high_out      = r_high_out;
   assign pending_count = r_pend;
   assign overflow_flag = r_ovf;
   assign error_flag    = r_err;
   assign flush_done    = r_flush_done;

endmodule

// File: tb/tb_range_encoder_renormalizer.sv
// tb/tb_range_encoder_renormalizer.sv - randomized self-checking bench with a behavioural renormalizer model
`timescale 1ns/1ps
module tb_range_encoder_renormalizer;

   localparam int PEND_W = 8;
   localparam int PMAX   = (1 << PEND_W) - 1;
   localparam int TMO    = 5000;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              in_valid = 1'b0;
   logic              flush = 1'b0;
   logic              bit_ready = 1'b0;
   logic [15:0]       low_in = 16'h0;
   logic [15:0]       high_in = 16'h0;
   logic              in_ready, bit_valid, bit_out, norm_valid;
   logic [15:0]       low_out, high_out;
   logic [PEND_W-1:0] pending_count;
   logic              overflow_flag, error_flag, flush_done;

   logic              in_valid2 = 1'b0;
   logic [15:0]       low_in2 = 16'h0;
   logic [15:0]       high_in2 = 16'h0;
   logic              flush2 = 1'b0;
   logic              bit_ready2 = 1'b1;
   logic              in_ready2, bit_valid2, bit_out2, norm_valid2;
   logic [15:0]       low_out2, high_out2;
   logic [1:0]        pending_count2;
   logic              overflow_flag2, error_flag2, flush_done2;

   range_encoder_renormalizer #(.PEND_W(PEND_W)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .low_in(low_in), .high_in(high_in), .flush(flush),
      .bit_valid(bit_valid), .bit_out(bit_out), .bit_ready(bit_ready),
      .norm_valid(norm_valid), .low_out(low_out), .high_out(high_out),
      .pending_count(pending_count), .overflow_flag(overflow_flag),
      .error_flag(error_flag), .flush_done(flush_done)
   );

   range_encoder_renormalizer #(.PEND_W(2)) u_dut2 (
      .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
      .low_in(low_in2), .high_in(high_in2), .flush(flush2),
      .bit_valid(bit_valid2), .bit_out(bit_out2), .bit_ready(bit_ready2),
      .norm_valid(norm_valid2), .low_out(low_out2), .high_out(high_out2),
      .pending_count(pending_count2), .overflow_flag(overflow_flag2),
      .error_flag(error_flag2), .flush_done(flush_done2)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;
   int rdy_mode = 1;

   // Reference state: interval, pending count, sticky flags, expected bit stream.
   int m_lo = 0, m_hi = 0, m_pend = 0;
   bit m_err = 1'b0, m_ovf = 1'b0, flush_exp = 1'b0;
   bit exp_bits[$];
   bit got_bits[$];
   bit prev_hold = 1'b0, prev_bit = 1'b0, exp_b = 1'b0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic m_emit(input bit b);
      exp_bits.push_back(b);
      repeat (m_pend) exp_bits.push_back(!b);
      m_pend = 0;
   endtask

   task automatic m_inc();
      if (m_pend == PMAX) m_ovf = 1'b1;
      else m_pend++;
   endtask

   task automatic model_interval(input int lo, input int hi);
      int  l = lo, h = hi, guard = 0;
      bit  done = 1'b0;
      if (l > h) begin
         m_err = 1'b1;
         done  = 1'b1;
      end
      while (!done && guard < 40) begin
         guard++;
         if (h < 32'h8000) begin
            m_emit(1'b0);
            l = (l * 2) & 32'hFFFF;
            h = (h * 2 + 1) & 32'hFFFF;
         end else if (l >= 32'h8000) begin
            m_emit(1'b1);
            l = ((l - 32'h8000) * 2) & 32'hFFFF;
            h = ((h - 32'h8000) * 2 + 1) & 32'hFFFF;
         end else if (l >= 32'h4000 && h < 32'hC000) begin
            m_inc();
            l = ((l - 32'h4000) * 2) & 32'hFFFF;
            h = ((h - 32'h4000) * 2 + 1) & 32'hFFFF;
         end else begin
            done = 1'b1;
         end
      end
      m_lo = l;
      m_hi = h;
   endtask

   task automatic model_flush();
      m_inc();
      m_emit(m_lo < 32'h4000 ? 1'b0 : 1'b1);
      m_lo = 0;
      m_hi = 32'hFFFF;
      m_pend = 0;
      flush_exp = 1'b1;
   endtask

   task automatic model_reset();
      m_lo = 0; m_hi = 0; m_pend = 0;
      m_err = 1'b0; m_ovf = 1'b0; flush_exp = 1'b0;
      exp_bits.delete();
   endtask

   always @(negedge clk) begin
      if (reset) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("hold_valid", bit_valid, 1'b1);
            chk("hold_bit", bit_out, prev_bit);
         end
         if (bit_valid && bit_ready) begin
            got_bits.push_back(bit_out);
            if (exp_bits.size() == 0) begin
               chk("extra_bit", 1'b1, 1'b0);
            end else begin
               exp_b = exp_bits.pop_front();
               chk("bit_value", bit_out, exp_b);
            end
         end
         if (norm_valid) begin
            chk("norm_low", low_out, m_lo);
            chk("norm_high", high_out, m_hi);
            chk("norm_pending", pending_count, m_pend);
            chk("norm_bits_left", exp_bits.size(), 0);
            chk("norm_err", error_flag, m_err);
            chk("norm_ovf", overflow_flag, m_ovf);
         end
         if (flush_done) begin
            chk("flush_done_expected", flush_exp, 1'b1);
            chk("flush_bits_left", exp_bits.size(), 0);
            chk("flush_pending", pending_count, 0);
            flush_exp = 1'b0;
         end
         prev_hold = bit_valid && !bit_ready;
         prev_bit  = bit_out;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 1) bit_ready = 1'b1;
         else if (rdy_mode == 2) bit_ready = 1'b0;
         else bit_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_interval(input logic [15:0] lo, input logic [15:0] hi);
      int n = 0;
      while (!in_ready && n < TMO) begin tick(); n++; end
      chk("in_ready_timeout", n < TMO, 1'b1);
      in_valid = 1'b1;
      low_in   = lo;
      high_in  = hi;
      model_interval(int'(lo), int'(hi));
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_norm(output int lat, output logic ir);
      lat = 0;
      do begin @(negedge clk); lat++; end while (!norm_valid && lat < TMO);
      ir = in_ready;
      chk("norm_timeout", lat < TMO, 1'b1);
      tick();
   endtask

   task automatic do_flush();
      int n = 0;
      while (!in_ready && n < TMO) begin tick(); n++; end
      chk("flush_ready_timeout", n < TMO, 1'b1);
      flush = 1'b1;
      model_flush();
      tick();
      flush = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!flush_done && n < TMO);
      chk("flush_timeout", n < TMO, 1'b1);
      tick();
   endtask

   task automatic chk_bits(input string name, input int n, input int val);
      int v = 0;
      foreach (got_bits[i]) v = (v << 1) | int'(got_bits[i]);
      chk({name, "_count"}, got_bits.size(), n);
      chk({name, "_bits"}, v, val);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, in_ready, 1'b0);
      chk({tag, "_bit_valid"}, bit_valid, 1'b0);
      chk({tag, "_bit_out"}, bit_out, 1'b0);
      chk({tag, "_norm_valid"}, norm_valid, 1'b0);
      chk({tag, "_low_out"}, low_out, 16'h0);
      chk({tag, "_high_out"}, high_out, 16'h0);
      chk({tag, "_pending"}, pending_count, 0);
      chk({tag, "_ovf"}, overflow_flag, 1'b0);
      chk({tag, "_err"}, error_flag, 1'b0);
      chk({tag, "_flush_done"}, flush_done, 1'b0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int          lat, kind, w, n;
      logic        ir, b0;
      logic [15:0] lo, hi;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("rst");
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      chk("rst_release_ready", in_ready, 1'b1);
      tick();

      got_bits.delete();
      start_interval(16'h2000, 16'hDFFF);
      wait_norm(lat, ir);
      chk("ns_latency", lat, 2);
      chk("ns_ready_at_norm", ir, 1'b0);
      chk("ns_ready_after", in_ready, 1'b1);
      chk("ns_low", low_out, 16'h2000);
      chk("ns_high", high_out, 16'hDFFF);
      chk_bits("ns", 0, 0);

      got_bits.delete();
      start_interval(16'h0000, 16'h3FFF);
      wait_norm(lat, ir);
      chk_bits("e1e1", 2, 0);
      chk("e1e1_low", low_out, 16'h0000);
      chk("e1e1_high", high_out, 16'hFFFF);

      got_bits.delete();
      start_interval(16'h9000, 16'hFFFF);
      wait_norm(lat, ir);
      chk_bits("e2", 1, 1);
      chk("e2_low", low_out, 16'h2000);
      chk("e2_high", high_out, 16'hFFFF);

      got_bits.delete();
      start_interval(16'h4000, 16'hBFFF);
      wait_norm(lat, ir);
      chk_bits("e3", 0, 0);
      chk("e3_pending", pending_count, 1);
      chk("e3_low", low_out, 16'h0000);
      chk("e3_high", high_out, 16'hFFFF);

      got_bits.delete();
      start_interval(16'h0000, 16'h7FFF);
      wait_norm(lat, ir);
      chk_bits("e3e1", 2, 1);
      chk("e3e1_pending", pending_count, 0);
      chk("e3e1_high", high_out, 16'hFFFF);

      got_bits.delete();
      start_interval(16'h6800, 16'h97FF);
      wait_norm(lat, ir);
      chk("fl_setup_pending", pending_count, 2);
      chk("fl_setup_low", low_out, 16'h2000);
      do_flush();
      chk_bits("flush", 4, 7);
      chk("flush_pending_after", pending_count, 0);

      rdy_mode = 2;
      got_bits.delete();
      start_interval(16'h0000, 16'h3FFF);
      n = 0;
      do begin @(negedge clk); n++; end while (!bit_valid && n < TMO);
      chk("bp_timeout", n < TMO, 1'b1);
      b0 = bit_out;
      chk("bp_first_bit", b0, 1'b0);
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", bit_valid, 1'b1);
         chk("bp_bit", bit_out, b0);
      end
      @(posedge clk); #1; reset = 1'b1;
      @(negedge clk);
      chk_reset_outputs("mid");
      model_reset();
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      chk("mid_release_ready", in_ready, 1'b1);
      rdy_mode = 0;
      tick();

      repeat (250) begin
         if ($urandom_range(0, 15) == 0) begin
            do_flush();
         end else begin
            kind = $urandom_range(0, 7);
            if (kind == 0) begin
               lo = 16'($urandom_range(1, 65535));
               hi = 16'($urandom_range(0, int'(lo) - 1));
            end else if (kind == 7) begin
               lo = 16'($urandom_range(16'h4000, 16'h7FFF));
               hi = 16'($urandom_range(16'h8000, 16'hBFFF));
            end else begin
               lo = 16'($urandom_range(0, 65535));
               w  = (kind < 4) ? $urandom_range(0, 255) : $urandom_range(0, 65535);
               hi = (int'(lo) + w > 65535) ? 16'hFFFF : 16'(int'(lo) + w);
            end
            start_interval(lo, hi);
            wait_norm(lat, ir);
         end
      end

      chk("p2_ovf_before", overflow_flag2, 1'b0);
      in_valid2 = 1'b1;
      low_in2   = 16'h7800;
      high_in2  = 16'h87FF;
      tick();
      in_valid2 = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!norm_valid2 && n < TMO);
      chk("p2_timeout", n < TMO, 1'b1);
      chk("p2_pending", pending_count2, 3);
      chk("p2_ovf", overflow_flag2, 1'b1);
      chk("p2_low", low_out2, 16'h0000);
      chk("p2_high", high_out2, 16'hFFFF);
      chk("p2_no_bits", bit_valid2, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
